// File: rtl/shift_engine_if.sv
// Load-side handshake bundle for shift_engine: a word, its mode and step count,
// presented with valid and accepted when ready is high.
interface shift_engine_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic [1:0]       load_mode;
  logic [CNT_W-1:0] load_count;

  modport master (
    output load_valid, load_data, load_mode, load_count,
    input  load_ready
  );

  modport slave (
    input  load_valid, load_data, load_mode, load_count,
    output load_ready
  );
endinterface

// File: rtl/shift_engine.sv
// Parametrised load/shift/rotate engine: loads a word, then runs a counted number of LSL/LSR/ASR/ROL steps.
// Optional abort port and aborted pulse are built in when SHIFT_ENGINE_ABORT_EN is defined.
module shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  shift_engine_if.slave    ld,
  input  logic             ser_in,
  input  logic             step_en,
`ifdef SHIFT_ENGINE_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [1:0] MODE_LSL = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;

  logic [1:0]       state;
  logic [1:0]       mode;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] next_data;
  logic             next_ser;

  // Handshake and status flags decode straight from the state register.
  assign ld.load_ready = (state == ST_IDLE);
  assign busy          = (state == ST_SHIFT) || (state == ST_DONE);
  assign done          = (state == ST_DONE);

  always_comb begin
    next_data = data_out;
    next_ser  = ser_out;
    case (mode)
      MODE_LSL: begin
        next_data = {data_out[WIDTH-2:0], ser_in};
        next_ser  = data_out[WIDTH-1];
      end
      MODE_LSR: begin
        next_data = {ser_in, data_out[WIDTH-1:1]};
        next_ser  = data_out[0];
      end
      MODE_ASR: begin
        next_data = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
        next_ser  = data_out[0];
      end
      default: begin
        next_data = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
        next_ser  = data_out[WIDTH-1];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      mode     <= MODE_LSL;
      count    <= '0;
      data_out <= '0;
      ser_out  <= 1'b0;
`ifdef SHIFT_ENGINE_ABORT_EN
      aborted  <= 1'b0;
`endif
    end else begin
`ifdef SHIFT_ENGINE_ABORT_EN
      aborted <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (ld.load_valid) begin
            data_out <= ld.load_data;
            mode     <= ld.load_mode;
            count    <= ld.load_count;
            state    <= (ld.load_count != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
`ifdef SHIFT_ENGINE_ABORT_EN
          if (abort) begin
            aborted <= 1'b1;
            state   <= ST_IDLE;
          end else
`endif
          // The count guard keeps the counter from ever wrapping below zero.
          if (step_en && (count != '0)) begin
            data_out <= next_data;
            ser_out  <= next_ser;
            count    <= count - 1'b1;
            if (count == CNT_W'(1)) state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_engine.sv
// Randomised self-checking bench for shift_engine against a word-level arithmetic model.
// Abort checks are compiled in when SHIFT_ENGINE_ABORT_EN is defined.
module tb_shift_engine;

  localparam int W    = 8;
  localparam int CW   = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         ser_in;
  logic         step_en;
  logic [W-1:0] data_out;
  logic         ser_out;
  logic         busy;
  logic         done;
`ifdef SHIFT_ENGINE_ABORT_EN
  logic         abort;
  logic         aborted;
`endif

  int total = 0;
  int bad   = 0;
  int m_data;
  int m_ser;

  shift_engine_if #(.WIDTH(W), .CNT_W(CW)) ld_if ();

  shift_engine #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld_if),
    .ser_in   (ser_in),
    .step_en  (step_en),
`ifdef SHIFT_ENGINE_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .data_out (data_out),
    .ser_out  (ser_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One step on the word as an integer: returns ser_out*2^W + new data.
  function automatic int refStep(input int d, input int mode, input int s);
    int nd;
    int so;
    case (mode)
      0: begin so = d / (1 << (W-1));     nd = ((d * 2) + s) & MASK; end
      1: begin so = d % 2;                nd = (d / 2) + s * (1 << (W-1)); end
      2: begin so = d % 2;                nd = (d / 2) + (d & (1 << (W-1))); end
      default: begin so = d / (1 << (W-1)); nd = ((d * 2) + so) & MASK; end
    endcase
    return so * (1 << W) + nd;
  endfunction

  // Runs one full load/shift/done operation and checks every cycle against the model.
  task automatic applyStimulus(input logic [W-1:0] d, input logic [1:0] mode, input logic [CW-1:0] cnt,
                               input logic [31:0] en_pat, input bit use_pat, input int ser_fix,
                               output int busy_cycles);
    int remaining;
    int idx;
    int r;
    bit en;
    bit s;
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = d;
    ld_if.load_mode  = mode;
    ld_if.load_count = cnt;
    step_en          = 1'($urandom_range(0, 1));
    checkOutput("ready_before_load", ld_if.load_ready, 1);
    tick();
    ld_if.load_valid = 1'b0;
    m_data      = int'(d);
    busy_cycles = 0;
    busy_cycles += int'(busy);
    checkOutput("load_data", data_out, m_data);
    checkOutput("load_ser_hold", ser_out, m_ser);
    checkOutput("load_ready_low", ld_if.load_ready, 0);
    checkOutput("load_done", done, (cnt == 0) ? 1 : 0);
    remaining = int'(cnt);
    idx = 0;
    while (remaining > 0 && idx < 200) begin
      en = use_pat ? ((idx < 32) ? en_pat[idx] : 1'b1) : ($urandom_range(0, 2) != 0);
      s  = (ser_fix < 0) ? 1'($urandom_range(0, 1)) : 1'(ser_fix);
      step_en          = en;
      ser_in           = s;
      ld_if.load_valid = 1'($urandom_range(0, 1));
      ld_if.load_data  = W'($urandom);
      tick();
      if (en) begin
        r = refStep(m_data, int'(mode), int'(s));
        m_data = r & MASK;
        m_ser  = r >> W;
        remaining--;
      end
      busy_cycles += int'(busy);
      checkOutput("shift_data", data_out, m_data);
      checkOutput("shift_ser", ser_out, m_ser);
      checkOutput("shift_done", done, (remaining == 0) ? 1 : 0);
      checkOutput("shift_busy", busy, 1);
      checkOutput("shift_ready", ld_if.load_ready, 0);
      idx++;
    end
    if (remaining > 0) checkOutput("shift_timeout", remaining, 0);
    // A load offered during the done cycle must not be taken.
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = W'(~m_data);
    step_en          = 1'b1;
    tick();
    checkOutput("post_done", done, 0);
    checkOutput("post_busy", busy, 0);
    checkOutput("post_ready", ld_if.load_ready, 1);
    checkOutput("no_load_in_done", data_out, m_data);
    checkOutput("post_ser", ser_out, m_ser);
    ld_if.load_valid = 1'b0;
    step_en          = 1'b0;
  endtask

  initial begin
    int bc;
    rst              = 1'b1;
    ser_in           = 1'b0;
    step_en          = 1'b0;
    ld_if.load_valid = 1'b0;
    ld_if.load_data  = '0;
    ld_if.load_mode  = 2'b00;
    ld_if.load_count = '0;
`ifdef SHIFT_ENGINE_ABORT_EN
    abort            = 1'b0;
`endif
    m_data = 0;
    m_ser  = 0;
    $display("[TB] shift_engine bench start");
    tick();
    tick();
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_ser", ser_out, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    rst = 1'b0;
    tick();
    checkOutput("rst_ready", ld_if.load_ready, 1);

    applyStimulus(8'hA5, 2'b00, 4'd3, 32'hFFFF_FFFF, 1'b1, 0, bc);
    checkOutput("lsl_final", data_out, 8'h28);
    checkOutput("lsl_ser", ser_out, 1);
    applyStimulus(8'h90, 2'b10, 4'd2, 32'hFFFF_FFFF, 1'b1, 0, bc);
    checkOutput("asr_final", data_out, 8'hE4);
    checkOutput("asr_ser", ser_out, 0);
    checkOutput("asr_busy_cycles", bc, 3);
    applyStimulus(8'h81, 2'b11, 4'd8, 32'hFFFF_FFFF, 1'b1, 0, bc);
    checkOutput("rol_final", data_out, 8'h81);
    checkOutput("rol_ser", ser_out, 1);
    applyStimulus(8'h3C, 2'b01, 4'd4, 32'h0000_0059, 1'b1, 1, bc);
    checkOutput("lsr_final", data_out, 8'hF3);
    applyStimulus(8'h6B, 2'b00, 4'd0, 32'h0, 1'b0, -1, bc);
    checkOutput("zero_count_data", data_out, 8'h6B);
    checkOutput("zero_count_busy", bc, 1);

    for (int k = 0; k < 25; k++)
      applyStimulus(W'($urandom), 2'($urandom_range(0, 3)), CW'($urandom_range(0, 15)), 32'h0, 1'b0, -1, bc);

    // Asynchronous reset in the middle of a count=5 LSL operation.
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 8'h5A;
    ld_if.load_mode  = 2'b00;
    ld_if.load_count = 4'd5;
    tick();
    ld_if.load_valid = 1'b0;
    step_en = 1'b1;
    ser_in  = 1'b1;
    tick();
    tick();
    checkOutput("pre_rst_data", data_out, 8'h6B);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_data", data_out, 0);
    checkOutput("mid_rst_ser", ser_out, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    tick();
    rst = 1'b0;
    m_data = 0;
    m_ser  = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checkOutput("after_rst_no_done", done, 0);
      checkOutput("after_rst_ready", ld_if.load_ready, 1);
    end
    step_en = 1'b0;

`ifdef SHIFT_ENGINE_ABORT_EN
    ld_if.load_valid = 1'b1;
    ld_if.load_data  = 8'hFF;
    ld_if.load_mode  = 2'b00;
    ld_if.load_count = 4'd6;
    tick();
    ld_if.load_valid = 1'b0;
    step_en = 1'b1;
    ser_in  = 1'b0;
    tick();
    tick();
    checkOutput("pre_abort_data", data_out, 8'hFC);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_data", data_out, 8'hFC);
    checkOutput("abort_pulse", aborted, 1);
    checkOutput("abort_no_done", done, 0);
    checkOutput("abort_idle", ld_if.load_ready, 1);
    tick();
    checkOutput("abort_pulse_end", aborted, 0);
    checkOutput("abort_no_done_late", done, 0);
    step_en = 1'b0;
    m_ser = 1;
`endif

    applyStimulus(8'hC3, 2'b11, 4'd5, 32'h0, 1'b0, -1, bc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
Name: shift_engine

Overview:
- Parametrised successor to the team's 8-bit load/shift-left register.
- Parallel-loads a WIDTH-bit word through a valid/ready handshake, then performs a programmed number of single-bit shift/rotate steps in one of four modes.
- Steps advance under a step enable, and a one-cycle done pulse marks completion.
- Sits between the pin-level I/O and downstream serial or parallel consumers (serializer, bit-banging, test-pattern generation).

Parameters:
- WIDTH, 8, data register width in bits; must be ≥2.
- CNT_W, 4, width of the step-count field; allows up to 2^CNT_W−1 steps per operation.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- load_valid, input, 1, load request.
- load_ready, output, 1, engine can accept a load; high only in IDLE.
- load_data, input, WIDTH, word captured on load.
- load_mode, input, 2, operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
- load_count, input, CNT_W, number of steps to perform.
- ser_in, input, 1, fill bit for LSL/LSR.
- step_en, input, 1, when high in SHIFT, one step is performed this cycle.
- data_out, output, WIDTH, current register contents (registered).
- ser_out, output, 1, bit most recently shifted or rotated out (registered).
- busy, output, 1, high in SHIFT and DONE.
- done, output, 1, one-cycle pulse: operation complete.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; data_out=0; ser_out=0; step counter=0; latched mode=00; done=0; busy=0; load_ready=1 once reset is released.
- States are IDLE, SHIFT and DONE.

IDLE:
- load_ready=1.
- On load_valid&&load_ready at an edge: data_out<=load_data, mode latched, counter<=load_count.
- Next state is SHIFT if load_count≠0, else DONE.
- load_valid low: no change.

SHIFT:
- load_ready=0; load_valid is ignored.
- If step_en=1: one step per the latched mode; counter decrements; when the counter was 1, next state is DONE.
- If step_en=0: register, counter and ser_out hold.
- ser_in and step_en are sampled at the same edge as the step.

Step definitions (W=WIDTH):
- LSL: data<={data[W-2:0],ser_in}; ser_out<=data[W-1].
- LSR: data<={ser_in,data[W-1:1]}; ser_out<=data[0].
- ASR: data<={data[W-1],data[W-1:1]}; ser_out<=data[0].
- ROL: data<={data[W-2:0],data[W-1]}; ser_out<=data[W-1].

DONE:
- Lasts exactly one cycle: done=1, busy=1, load_ready=0.
- Next state is IDLE unconditionally; data_out and ser_out hold.

Timing and boundary rules:
- Latency: load accepted at edge E, N steps with step_en held high end at edge E+N, done high during cycle E+N to E+N+1, IDLE and load_ready=1 after edge E+N+1.
- load_count=0: DONE immediately after the load edge; data_out equals load_data; ser_out is unchanged.
- Counter never wraps; a step is only taken when the counter is ≥1.
- ROL with count=WIDTH returns the original word.
- Reset asserted mid-operation aborts instantly to reset values; no done pulse.
- A load cannot be accepted in the same cycle as done; back-to-back operations are separated by ≥1 IDLE cycle.
- All outputs are driven from registers or decoded from the state register only; there is no combinational input-to-output path.

Optional Feature:
- Macro: SHIFT_ENGINE_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output aborted (1 bit, reset 0).
  - In SHIFT, abort=1 at an edge: next state IDLE, aborted=1 for one cycle, no done pulse.
  - data_out and ser_out keep their partially shifted values.
  - abort has priority over step_en in the same cycle.
  - abort is ignored in IDLE and DONE.
- When undefined: neither port exists; SHIFT exits only via counter expiry or rst.

Test Plan:
- WIDTH=8, load 0xA5, mode LSL, count 3, ser_in=0, step_en=1 → data_out 0x4A, 0x94, 0x28 on successive edges; ser_out final=1; done high for exactly 1 cycle after the third step; load_ready returns the next cycle.
- Load 0x90, mode ASR, count 2 → data_out 0xC8 then 0xE4; ser_out final=0; busy high for 3 cycles total.
- Load 0x81, mode ROL, count 8 → data_out back to 0x81 after 8 steps; ser_out=1; done pulse once.
- Load 0x3C, LSR, count 4, ser_in=1, step_en toggled 1,0,0,1,1,0,1 → value holds on step_en=0 cycles; final 0xF3 after the 4th enabled step; done follows.
- Load with count=0 → done the next cycle, data_out=load_data; then assert rst mid-way through a count=5 LSL op → all outputs 0 immediately, no done, load_ready=1 after release.
- With SHIFT_ENGINE_ABORT_EN: load 0xFF LSL count 6, abort after 2 steps with step_en also high → data_out=0xFC, aborted pulse, no done, IDLE the next cycle.
